// File: rtl/periodic_sample_sender.sv
// Periodic round-robin sample transmitter: arms on any non-zero channel sample, then
// sends one captured sample every PERIOD clocks. Build option: SENDER_SKIP_DUP_EN.
module periodic_sample_sender #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned PERIOD     = 97,
  parameter int unsigned STROBE_LEN = 3,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     arm_clear,
  output logic [DATA_W-1:0]        send_data,
  output logic [CH_W-1:0]          send_ch,
  output logic                     send_flag,
  output logic                     armed,
  output logic [15:0]              send_count
);
  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned STB_W = $clog2(STROBE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PERIOD - 2);
  localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(NUM_CH - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STROBE_LEN);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CH_W-1:0]   ptr_q;
  logic [STB_W-1:0]  strb_q;
  logic              send_ev;
  logic              clr_ev;
  logic              emit;
  logic [DATA_W-1:0] cur;

  assign cur   = sample_in[ptr_q*DATA_W +: DATA_W];
  assign armed = (state_q == ARMED);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    send_ev = 1'b0;
    clr_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!arm_clear && (|sample_in)) state_d = ARMED;
      end
      ARMED: begin
        if (arm_clear) begin
          state_d = IDLE;
          clr_ev  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          send_ev = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SENDER_SKIP_DUP_EN
  logic [DATA_W-1:0] last_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) last_q[i] <= '0;
    end else if (emit) begin
      last_q[ptr_q] <= cur;
    end
  end

  // A repeat of the channel's last sent value advances the schedule silently.
  assign emit = send_ev && (cur != last_q[ptr_q]);
`else
  assign emit = send_ev;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ptr_q      <= '0;
      strb_q     <= '0;
      send_flag  <= 1'b0;
      send_data  <= '0;
      send_ch    <= '0;
      send_count <= '0;
    end else if (state_q != ARMED || clr_ev) begin
      cnt_q     <= '0;
      ptr_q     <= '0;
      strb_q    <= '0;
      send_flag <= 1'b0;
    end else begin
      // Strobe ends after STROBE_LEN cycles, or early so the next send always rises.
      if (send_flag) begin
        if (strb_q >= STB_MAX || cnt_q == CNT_PRE) send_flag <= 1'b0;
        else                                        strb_q    <= strb_q + 1'b1;
      end
      if (send_ev) begin
        cnt_q <= '0;
        ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (emit) begin
        send_data <= cur;
        send_ch   <= ptr_q;
        send_flag <= 1'b1;
        strb_q    <= STB_W'(1);
        if (send_count != '1) send_count <= send_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_periodic_sample_sender.sv
// Self-checking bench for periodic_sample_sender: vector table, directed corner
// sequences and a randomized run against a schedule-level reference model.
module tb_periodic_sample_sender;
`ifdef SENDER_SKIP_DUP_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int unsigned passed = 0;
  int unsigned total  = 0;

  // Instance A: defaults
  logic [7:0]  a_smp, a_data;
  logic        a_clr, a_flag, a_armed;
  logic [0:0]  a_ch;
  logic [15:0] a_cnt;
  periodic_sample_sender u_a (
    .clk(clk), .rst(rst), .sample_in(a_smp), .arm_clear(a_clr), .send_data(a_data),
    .send_ch(a_ch), .send_flag(a_flag), .armed(a_armed), .send_count(a_cnt));

  // Instance B: three channels
  logic [23:0] b_smp;
  logic [7:0]  b_data;
  logic        b_clr, b_flag, b_armed;
  logic [1:0]  b_ch;
  logic [15:0] b_cnt;
  periodic_sample_sender #(.NUM_CH(3), .PERIOD(10), .STROBE_LEN(2)) u_b (
    .clk(clk), .rst(rst), .sample_in(b_smp), .arm_clear(b_clr), .send_data(b_data),
    .send_ch(b_ch), .send_flag(b_flag), .armed(b_armed), .send_count(b_cnt));

  // Instance C: strobe longer than period
  logic [7:0]  c_smp, c_data;
  logic        c_clr, c_flag, c_armed;
  logic [0:0]  c_ch;
  logic [15:0] c_cnt;
  periodic_sample_sender #(.PERIOD(4), .STROBE_LEN(6)) u_c (
    .clk(clk), .rst(rst), .sample_in(c_smp), .arm_clear(c_clr), .send_data(c_data),
    .send_ch(c_ch), .send_flag(c_flag), .armed(c_armed), .send_count(c_cnt));

  // Instance D: short period for duplicate suppression
  logic [7:0]  d_smp, d_data;
  logic        d_clr, d_flag, d_armed;
  logic [0:0]  d_ch;
  logic [15:0] d_cnt;
  periodic_sample_sender #(.PERIOD(5)) u_d (
    .clk(clk), .rst(rst), .sample_in(d_smp), .arm_clear(d_clr), .send_data(d_data),
    .send_ch(d_ch), .send_flag(d_flag), .armed(d_armed), .send_count(d_cnt));

  typedef struct {
    logic        rst;
    logic        clr;
    logic [7:0]  smp;
    int unsigned n;
    logic        armed;
    logic        flag;
    logic [7:0]  data;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic c, input logic [7:0] s, input int unsigned n,
                              input logic ea, input logic ef, input logic [7:0] ed, input int unsigned ec);
    vec_t v;
    v.rst = r; v.clr = c; v.smp = s; v.n = n;
    v.armed = ea; v.flag = ef; v.data = ed; v.cnt = 16'(ec);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model for instance B: sends fall on every PERIOD-th edge after arming,
  // channel = (send number) mod NUM_CH, flag high while edges-since-emit < min(STROBE_LEN, PERIOD-1).
  localparam int unsigned MP  = 10;
  localparam int unsigned MN  = 3;
  localparam int unsigned MSL = 2;
  localparam int unsigned FL  = (MSL < MP - 1) ? MSL : MP - 1;
  localparam int unsigned BIG = 32'h4000_0000;

  bit          m_armed;
  int unsigned m_t, m_age, m_ch, m_count;
  logic [7:0]  m_data;
  logic [7:0]  m_last [MN];

  task automatic model_edge(input logic r, input logic c, input logic [23:0] s);
    int unsigned k;
    logic [7:0] v;
    if (r) begin
      m_armed = 0; m_t = 0; m_age = BIG; m_data = '0; m_ch = 0; m_count = 0;
      for (int i = 0; i < MN; i++) m_last[i] = '0;
    end else if (!m_armed) begin
      if (!c && s != '0) begin m_armed = 1; m_t = 0; m_age = BIG; end
    end else if (c) begin
      m_armed = 0; m_age = BIG;
    end else begin
      m_t++;
      if (m_age < BIG) m_age++;
      if (m_t % MP == 0) begin
        k = (m_t / MP - 1) % MN;
        v = s[k*8 +: 8];
        if (!DUP || v != m_last[k]) begin
          m_data = v; m_ch = k; m_last[k] = v; m_age = 0;
          if (m_count < 65535) m_count++;
        end
      end
    end
  endtask

  initial begin
    int unsigned c2, c3, c4;
    int unsigned rises;
    logic prev, exp_emit;

    rst = 1'b1;
    a_smp = '0; a_clr = 1'b0; b_smp = '0; b_clr = 1'b0;
    c_smp = '0; c_clr = 1'b0; d_smp = '0; d_clr = 1'b0;

    // Instance A: arm, period, strobe width, zero-sample sends, clear vs send, reset mid-strobe
    c2 = DUP ? 1 : 2;
    c3 = c2 + 1;
    c4 = c3 + 1;
    tbl.push_back(mk(1, 0, 8'h00,   3, 0, 0,    8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 500, 0, 0,    8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h2A,   1, 1, 0,    8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h2A,  96, 1, 0,    8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h2A,   1, 1, 1,    8'h2A, 1));
    tbl.push_back(mk(0, 0, 8'h2A,   2, 1, 1,    8'h2A, 1));
    tbl.push_back(mk(0, 0, 8'h2A,   1, 1, 0,    8'h2A, 1));
    tbl.push_back(mk(0, 0, 8'h2A,  94, 1, !DUP, 8'h2A, c2));
    tbl.push_back(mk(0, 0, 8'h00,  97, 1, 1,    8'h00, c3));
    tbl.push_back(mk(0, 0, 8'h55,  96, 1, 0,    8'h00, c3));
    tbl.push_back(mk(0, 1, 8'h55,   1, 0, 0,    8'h00, c3));
    tbl.push_back(mk(0, 1, 8'h55,   1, 0, 0,    8'h00, c3));
    tbl.push_back(mk(0, 0, 8'h55,   1, 1, 0,    8'h00, c3));
    tbl.push_back(mk(0, 0, 8'h55,  97, 1, 1,    8'h55, c4));
    tbl.push_back(mk(0, 0, 8'h55,   1, 1, 1,    8'h55, c4));
    tbl.push_back(mk(1, 0, 8'h55,   1, 0, 0,    8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; a_clr = tbl[i].clr; a_smp = tbl[i].smp;
      tick(tbl[i].n);
      check($sformatf("vec%0d", i), {a_armed, a_flag, a_data, a_cnt, a_ch},
            {tbl[i].armed, tbl[i].flag, tbl[i].data, tbl[i].cnt, 1'b0});
    end

    // Round-robin across three channels
    rst = 1'b1; tick(2); rst = 1'b0;
    b_smp = {8'h03, 8'h02, 8'h01};
    tick(1);
    check("rr_armed", b_armed, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(9);
      check($sformatf("rr_gap%0d", i), b_flag, 1'b0);
      tick(1);
      exp_emit = !(DUP && i == 3);
      check($sformatf("rr_flag%0d", i), b_flag, exp_emit);
      check($sformatf("rr_chdata%0d", i), {b_ch, b_data},
            exp_emit ? {2'(i % 3), 8'(i % 3 + 1)} : {2'd2, 8'h03});
    end

    // Strobe clamp: every send must produce a rising edge
    rst = 1'b1; tick(1); rst = 1'b0;
    c_smp = 8'h01; tick(1);
    tick(4);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("clamp%0d", j), c_flag, (j % 4) != 3);
      c_smp = 8'(j + 2);
      tick(1);
    end
    check("clamp_end", {c_flag, c_cnt}, {1'b1, 16'd3});

`ifdef SENDER_SKIP_DUP_EN
    rst = 1'b1; tick(1); rst = 1'b0;
    d_smp = 8'h07; tick(1);
    rises = 0; prev = d_flag;
    for (int j = 0; j < 20; j++) begin
      tick(1);
      if (d_flag && !prev) rises++;
      prev = d_flag;
    end
    check("dup_rises", rises, 1);
    check("dup_count", d_cnt, 16'd1);
    d_smp = 8'h08; tick(5);
    check("dup_new", {d_flag, d_data, d_cnt}, {1'b1, 8'h08, 16'd2});
`endif

    // Randomized run on instance B against the reference model
    rst = 1'b1; b_clr = 1'b0; b_smp = '0;
    @(posedge clk); model_edge(1'b1, 1'b0, 24'h0); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst   = ($urandom_range(0, 299) == 0);
      b_clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) b_smp = '0;
      else for (int k = 0; k < 3; k++)
        b_smp[k*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 3));
      @(posedge clk);
      model_edge(rst, b_clr, b_smp);
      #1;
      check($sformatf("rand%0d", cyc), {b_armed, b_flag, b_ch, b_data, b_cnt},
            {m_armed, (m_armed && m_age < FL), 2'(m_ch), m_data, 16'(m_count)});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/periodic_sample_sender.md
Name: periodic_sample_sender

Overview:
- Parametrised periodic sample transmitter. Arms when any input channel carries a non-zero sample.
- Once armed, emits one captured sample every PERIOD clocks, round-robin across NUM_CH channels.
- Each emission carries a channel tag and a strobe of STROBE_LEN cycles.
- Sits between the sample source (keypad/number logic) and the SD/serial writer, which latches send_data on the rising edge of send_flag.

Parameters:
- DATA_W, 8, sample width in bits.
- NUM_CH, 1, number of channels (1..16). CH_W = max(1, clog2(NUM_CH)).
- PERIOD, 97, clocks between consecutive sends (>= 2).
- STROBE_LEN, 3, clocks send_flag stays high after a send (1..PERIOD-1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  NUM_CH*DATA_W  channel samples; channel k occupies bits [k*DATA_W +: DATA_W].
- arm_clear  in  1  synchronous request to disarm.
- send_data  out  DATA_W  captured sample of the last send.
- send_ch  out  CH_W  channel index of the last send.
- send_flag  out  1  send strobe.
- armed  out  1  high while in ARMED state.
- send_count  out  16  number of sends since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, period counter 0, channel pointer 0, strobe counter 0. All outputs 0 (send_data, send_ch, send_flag, armed, send_count). Reset dominates every other input, including mid-strobe.
- States: IDLE and ARMED.
- IDLE -> ARMED at an edge E0 when any channel slice of sample_in is non-zero and arm_clear=0.
  - After E0: armed=1, counter=0, channel pointer=0.
- ARMED: counter increments by 1 each edge.
- Send event: at an edge where counter==PERIOD-1:
  - send_data <= slice[pointer]; send_ch <= pointer; send_flag <= 1.
  - counter <= 0; strobe counter <= 1.
  - pointer <= pointer+1, wrapping NUM_CH-1 -> 0.
  - send_count <= send_count+1, saturating.
- First send is visible after edge E0+PERIOD; subsequent sends every PERIOD edges after that.
- Sample is captured at the send edge only. send_data and send_ch hold their values between sends.
- Strobe: send_flag stays high for exactly STROBE_LEN cycles, then 0 until the next send.
  - If STROBE_LEN >= PERIOD, the flag is forced low on the cycle before the next send, so every send produces a rising edge.
- Once armed, sending continues even if all samples return to 0.
- arm_clear=1 in ARMED, at that edge:
  - state -> IDLE; armed, send_flag, counter, pointer -> 0.
  - send_data, send_ch and send_count hold.
  - Clear wins over a coincident send edge; no send occurs.
- arm_clear=1 with a non-zero sample in IDLE: stays IDLE. Re-arming is evaluated at the next edge where arm_clear=0.
- NUM_CH=1: pointer is constant 0 and send_ch is always 0.

Optional Feature:
- Macro: SENDER_SKIP_DUP_EN.
- Defined:
  - Per-channel register of the last value sent (reset 0).
  - At a send edge, if slice[pointer] equals that channel's last sent value: no strobe, send_data/send_ch/send_count unchanged, but counter and pointer still advance.
  - A zero sample is never sent before the first non-zero send on that channel.
- Not defined: every send edge emits unconditionally.

Test Plan:
- Reset/idle (defaults): hold rst 3 cycles, then samples 0 for 500 cycles -> all outputs remain 0, armed=0.
- Arm and period (defaults): sample_in=8'h2A at edge E0 -> armed=1 after E0. send_flag rises after E0+97 with send_data=8'h2A, low after E0+100, rises again after E0+194. send_count=2.
- Round-robin (NUM_CH=3, PERIOD=10, STROBE_LEN=2): samples {8'h03,8'h02,8'h01} -> send_ch sequence 0,1,2,0 with data 8'h01,8'h02,8'h03,8'h01, flags 10 cycles apart.
- Clear vs send collision (defaults): arm, then assert arm_clear on the edge where counter==96 -> no flag, armed=0, send_count unchanged. Re-arms one cycle after arm_clear drops.
- Strobe clamp (PERIOD=4, STROBE_LEN=6): flag pattern 1,1,1,0 repeating; one rising edge per send.
- SENDER_SKIP_DUP_EN (PERIOD=5): hold sample 8'h07 for 4 periods -> exactly one strobe, send_count=1. Change to 8'h08 -> one more strobe on the next send edge.
